// File: rtl/dac_pkg.sv
// Shared definitions for the DAC frame sequencer: FSM states, channel mode
// encodings, frame layout constants and the 32-bit write-frame assembler.
package dac_pkg;

  localparam int         FRAME_W = 32;
  localparam logic [3:0] PAD_HI  = 4'hF;
  localparam logic [7:0] PAD_LO  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  localparam logic [1:0] MODE_MUTE  = 2'd0;
  localparam logic [1:0] MODE_SRC_A = 2'd1;
  localparam logic [1:0] MODE_B_OFS = 2'd2;
  localparam logic [1:0] MODE_B_RAW = 2'd3;

  // Samples arrive already left-justified to 12 bits, so inverting bit 11
  // turns a two's-complement value into offset binary for any DATA_W.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [3:0]  chan,
    input logic [3:0]  cmd,
    input logic [11:0] smp_a,
    input logic [11:0] smp_b,
    input logic [1:0]  mode
  );
    logic [11:0] data;
    case (mode)
      MODE_SRC_A: data = smp_a;
      MODE_B_OFS: data = smp_b ^ 12'h800;
      MODE_B_RAW: data = smp_b;
      default:    data = 12'h000;
    endcase
    return {PAD_HI, cmd, chan, data, PAD_LO};
  endfunction

endpackage

// File: rtl/dac_frame_sequencer_if.sv
// Serial DAC pin bundle: data, active-low frame sync and serial clock.
// The sequencer drives it (master); the DAC or a monitor observes it (slave).
interface dac_frame_sequencer_if;

  logic dac_din;
  logic dac_sync_n;
  logic dac_sclk;

  modport master (output dac_din, output dac_sync_n, output dac_sclk);
  modport slave  (input  dac_din, input  dac_sync_n, input  dac_sclk);

endinterface

// File: rtl/dac_frame_shifter.sv
// 32-bit frame serialiser: load a word, shift it MSB first at CLK_DIV clk
// cycles per bit. sclk is high for the first half of each bit period and
// idles high; sync_n is low exactly while a frame is being shifted.
module dac_frame_shifter
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [FRAME_W-1:0] word,
  output logic               active,
  output logic               last_bit,
  dac_frame_sequencer_if.master dac
);

  localparam int DIV_W = $clog2(CLK_DIV);

  logic [FRAME_W-1:0] shreg;
  logic [4:0]         bit_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic               period_end;

  assign period_end = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_bit   = active && period_end && (bit_cnt == 5'd31);

  // Shift register with bit-period and bit-index counters; a load restarts the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      shreg   <= '0;
      bit_cnt <= 5'd0;
      div_cnt <= '0;
    end else if (load) begin
      active  <= 1'b1;
      shreg   <= word;
      bit_cnt <= 5'd0;
      div_cnt <= '0;
    end else if (active) begin
      if (period_end) begin
        div_cnt <= '0;
        bit_cnt <= bit_cnt + 5'd1;
        shreg   <= {shreg[FRAME_W-2:0], 1'b0};
        if (bit_cnt == 5'd31) begin
          active <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Pins are pure functions of registered state, so reset forces idle levels at once.
  assign dac.dac_din    = active & shreg[FRAME_W-1];
  assign dac.dac_sync_n = ~active;
  assign dac.dac_sclk   = ~active | (div_cnt < DIV_W'(CLK_DIV / 2));

endmodule

// File: rtl/dac_frame_sequencer.sv
// Captures one sample per channel on start, then writes one 32-bit frame per
// channel to a serial DAC with GAP_CYC idle cycles after each frame.
// Starts arriving while busy (or in the done cycle) are dropped and flag overrun.
module dac_frame_sequencer
  import dac_pkg::*;
#(
  parameter int         CHANNELS = 2,
  parameter int         DATA_W   = 12,
  parameter int         CLK_DIV  = 2,
  parameter int         GAP_CYC  = 2,
  parameter logic [3:0] CMD      = 4'b0011
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [CHANNELS*DATA_W-1:0] src_a,
  input  logic [CHANNELS*DATA_W-1:0] src_b,
  input  logic [CHANNELS*2-1:0]      mode,
  input  logic                       clr_overrun,
  dac_frame_sequencer_if.master      dac,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
);

  localparam int GAP_W = $clog2(GAP_CYC + 1);

  state_t                     state, state_nxt;
  logic [3:0]                 chan_q;
  logic [GAP_W-1:0]           gap_cnt;
  logic [CHANNELS*DATA_W-1:0] src_a_q, src_b_q;
  logic [CHANNELS*2-1:0]      mode_q;
  logic                       done_q, overrun_q;
  logic                       accept, load, gap_end, last_chan;
  logic                       sh_active, sh_last;
  logic [3:0]                 ld_chan;
  logic [DATA_W-1:0]          sel_a, sel_b;
  logic [1:0]                 sel_m;
  logic [FRAME_W-1:0]         ld_word;

  function automatic logic [11:0] justify(input logic [DATA_W-1:0] s);
    return 12'(s) << (12 - DATA_W);
  endfunction

  // done_q still counts as busy for start acceptance so the done cycle rejects a strobe.
  assign accept    = (state == IDLE) && start && !done_q;
  assign gap_end   = (state == GAP) && (gap_cnt == GAP_W'(GAP_CYC - 1));
  assign last_chan = (chan_q == 4'(CHANNELS - 1));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and frame load strobe.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT: begin
        if (sh_last) state_nxt = GAP;
      end
      GAP: begin
        if (gap_end) begin
          if (last_chan) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = SHIFT;
            load      = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Channel 0 is built straight from the live inputs on the accept edge; later channels use the latch.
  always_comb begin
    ld_chan = 4'd0;
    sel_a   = src_a[DATA_W-1:0];
    sel_b   = src_b[DATA_W-1:0];
    sel_m   = mode[1:0];
    if (state != IDLE) begin
      ld_chan = chan_q + 4'd1;
      sel_a   = src_a_q[int'(ld_chan)*DATA_W +: DATA_W];
      sel_b   = src_b_q[int'(ld_chan)*DATA_W +: DATA_W];
      sel_m   = mode_q[int'(ld_chan)*2 +: 2];
    end
  end

  assign ld_word = build_frame(ld_chan, CMD, justify(sel_a), justify(sel_b), sel_m);

  // Sample latch, channel counter and gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_a_q <= '0;
      src_b_q <= '0;
      mode_q  <= '0;
      chan_q  <= 4'd0;
      gap_cnt <= '0;
    end else begin
      if (accept) begin
        src_a_q <= src_a;
        src_b_q <= src_b;
        mode_q  <= mode;
        chan_q  <= 4'd0;
      end else if (load) begin
        chan_q <= ld_chan;
      end
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

  // Completion pulse and sticky overrun; a new overrun beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= gap_end && last_chan;
      if (start && ((state != IDLE) || done_q)) overrun_q <= 1'b1;
      else if (clr_overrun)                     overrun_q <= 1'b0;
    end
  end

  assign busy    = (state != IDLE);
  assign done    = done_q;
  assign overrun = overrun_q;

  dac_frame_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .word     (ld_word),
    .active   (sh_active),
    .last_bit (sh_last),
    .dac      (dac)
  );

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Bench for dac_frame_sequencer: a 2-channel/12-bit/div-2 instance and a
// 4-channel/8-bit/div-4 instance, pin-level frame decoding and a frame model.
module tb_dac_frame_sequencer;

  localparam int GAPC = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, start1, clr;
  logic [23:0] src_a0, src_b0;
  logic [3:0]  mode0;
  logic [31:0] src_a1, src_b1;
  logic [7:0]  mode1;
  logic busy0, done0, ovr0, busy1, done1, ovr1;

  dac_frame_sequencer_if if0 ();
  dac_frame_sequencer_if if1 ();

  dac_frame_sequencer #(.CHANNELS(2), .DATA_W(12), .CLK_DIV(2), .GAP_CYC(GAPC), .CMD(4'b0011)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .src_a(src_a0), .src_b(src_b0), .mode(mode0),
    .clr_overrun(clr), .dac(if0), .busy(busy0), .done(done0), .overrun(ovr0));

  dac_frame_sequencer #(.CHANNELS(4), .DATA_W(8), .CLK_DIV(4), .GAP_CYC(GAPC), .CMD(4'b0011)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .src_a(src_a1), .src_b(src_b1), .mode(mode1),
    .clr_overrun(clr), .dac(if1), .busy(busy1), .done(done1), .overrun(ovr1));

  always #5 clk = ~clk;

  int unsigned cyc_now = 0;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  int n_cmp = 0;
  int n_fail = 0;
  int unsigned acc_cyc = 0;

  typedef struct {
    int          id;
    logic [31:0] frame;
    int          low;
    int          gap;
  } cap_t;

  cap_t        mq[$];
  logic [31:0] exp_q[$];

  logic m_sync [2];
  logic m_sclk [2];
  logic m_din  [2];
  logic m_busy [2];
  assign m_sync[0] = if0.dac_sync_n;
  assign m_sclk[0] = if0.dac_sclk;
  assign m_din[0]  = if0.dac_din;
  assign m_busy[0] = busy0;
  assign m_sync[1] = if1.dac_sync_n;
  assign m_sclk[1] = if1.dac_sclk;
  assign m_din[1]  = if1.dac_din;
  assign m_busy[1] = busy1;

  // Pin-level decoder: shifts din on each falling sclk, measures sync_n low time and the high gap before each frame.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    logic        inframe = 1'b0;
    logic        cnting = 1'b0;
    logic        psclk = 1'b1;
    int          low = 0;
    int          hi = 0;
    int          gap = -1;
    logic [31:0] sh = '0;
    always @(negedge clk) begin
      if (!rst_n) begin
        inframe <= 1'b0;
        cnting  <= 1'b0;
      end else if (!m_sync[g]) begin
        if (!inframe) begin
          inframe <= 1'b1;
          low     <= 1;
          sh      <= '0;
          gap     <= cnting ? hi : -1;
        end else begin
          low <= low + 1;
          if (psclk && !m_sclk[g]) sh <= {sh[30:0], m_din[g]};
        end
      end else begin
        if (inframe) begin
          inframe <= 1'b0;
          mq.push_back('{id: g, frame: sh, low: low, gap: gap});
          cnting  <= 1'b1;
          hi      <= 1;
        end else begin
          if (cnting) hi <= hi + 1;
          if (!m_busy[g]) cnting <= 1'b0;
        end
      end
      psclk <= m_sclk[g];
    end
  end

  function automatic int n_ch(int id);      return (id == 0) ? 2 : 4;  endfunction
  function automatic int dw(int id);        return (id == 0) ? 12 : 8; endfunction
  function automatic int divn(int id);      return (id == 0) ? 2 : 4;  endfunction
  function automatic int busy_time(int id); return n_ch(id) * (32 * divn(id) + GAPC); endfunction

  function automatic logic get_busy(int id); return (id == 0) ? busy0 : busy1; endfunction
  function automatic logic get_done(int id); return (id == 0) ? done0 : done1; endfunction
  function automatic logic get_sync(int id); return (id == 0) ? if0.dac_sync_n : if1.dac_sync_n; endfunction

  // Reference frame from the field rules: offset binary is the sample plus half range, modulo full range.
  function automatic logic [31:0] ref_frame(int ch, int m, int a, int b, int w);
    int d;
    case (m)
      0:       d = 0;
      1:       d = a;
      2:       d = (b + (1 << (w - 1))) % (1 << w);
      default: d = b;
    endcase
    d = d * (1 << (12 - w));
    return (32'hF << 28) | (32'h3 << 24) | (32'(ch) << 20) | (32'(d) << 8) | 32'hFF;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(int id);
    exp_q.delete();
    for (int c = 0; c < n_ch(id); c++) begin
      int a, b, m;
      if (id == 0) begin
        a = int'(src_a0[c*12 +: 12]); b = int'(src_b0[c*12 +: 12]); m = int'(mode0[c*2 +: 2]);
      end else begin
        a = int'(src_a1[c*8 +: 8]);   b = int'(src_b1[c*8 +: 8]);   m = int'(mode1[c*2 +: 2]);
      end
      exp_q.push_back(ref_frame(c, m, a, b, dw(id)));
    end
  endtask

  task automatic set_start(int id, logic v);
    if (id == 0) start0 = v;
    else         start1 = v;
  endtask

  task automatic scramble(int id);
    if (id == 0) begin
      src_a0 = 24'($urandom); src_b0 = 24'($urandom); mode0 = 4'($urandom);
    end else begin
      src_a1 = $urandom; src_b1 = $urandom; mode1 = 8'($urandom);
    end
  endtask

  task automatic start_seq(int id);
    build_exp(id);
    @(negedge clk);
    set_start(id, 1'b1);
    @(negedge clk);
    set_start(id, 1'b0);
    acc_cyc = cyc_now;
    chk("accept_busy", 32'(get_busy(id)), 32'd1);
    chk("accept_sync_n", 32'(get_sync(id)), 32'd0);
  endtask

  task automatic wait_done(int id);
    int lim;
    lim = busy_time(id) + 40;
    while (!get_done(id) && int'(cyc_now - acc_cyc) < lim) @(negedge clk);
    chk("done_time", 32'(cyc_now - acc_cyc), 32'(busy_time(id)));
    chk("busy_in_done", 32'(get_busy(id)), 32'd0);
  endtask

  task automatic check_frames(int id);
    cap_t cap;
    chk("frame_count", 32'(mq.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (mq.size() == 0) break;
      cap = mq.pop_front();
      chk("frame", cap.frame, exp_q[i]);
      chk("sync_low_len", 32'(cap.low), 32'(32 * divn(id)));
      chk("gap_len", 32'(cap.gap), (i == 0) ? 32'hFFFF_FFFF : 32'(GAPC));
    end
    mq.delete();
  endtask

  task automatic finish_seq(int id);
    wait_done(id);
    check_frames(id);
    @(negedge clk);
    chk("done_one_cycle", 32'(get_done(id)), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; clr = 1'b0;
    src_a0 = '0; src_b0 = '0; mode0 = '0;
    src_a1 = '0; src_b1 = '0; mode1 = '0;
    repeat (3) @(negedge clk);

    chk("rst_sync_n", 32'(if0.dac_sync_n), 32'd1);
    chk("rst_din", 32'(if0.dac_din), 32'd0);
    chk("rst_sclk", 32'(if0.dac_sclk), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_overrun", 32'(ovr0), 32'd0);
    chk("rst_sync_n_4ch", 32'(if1.dac_sync_n), 32'd1);
    rst_n = 1'b1;

    // ch0 raw src_a 0xABC, ch1 muted
    src_a0 = {12'h000, 12'hABC}; src_b0 = 24'h123456; mode0 = {2'd0, 2'd1};
    start_seq(0); finish_seq(0);

    // offset binary extremes, then raw source B
    src_b0 = {12'h7FF, 12'h800}; mode0 = {2'd2, 2'd2};
    start_seq(0); finish_seq(0);
    mode0 = {2'd3, 2'd3};
    start_seq(0); finish_seq(0);

    // random samples/modes; inputs change mid-sequence
    for (int r = 0; r < 6; r++) begin
      scramble(0);
      start_seq(0);
      repeat (30 + r * 9) @(negedge clk);
      scramble(0);
      finish_seq(0);
    end

    // overrun: mid-frame strobe, clear, then strobe+clear together
    scramble(0);
    start_seq(0);
    repeat (20) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("overrun_set", 32'(ovr0), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("overrun_clr", 32'(ovr0), 32'd0);
    start0 = 1'b1; clr = 1'b1;
    @(negedge clk);
    start0 = 1'b0; clr = 1'b0;
    chk("overrun_set_wins", 32'(ovr0), 32'd1);
    finish_seq(0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("overrun_clr_idle", 32'(ovr0), 32'd0);

    // strobe held through the done cycle: first edge rejected, next edge accepted
    scramble(0);
    start_seq(0);
    wait_done(0);
    check_frames(0);
    scramble(0);
    build_exp(0);
    start0 = 1'b1;
    @(negedge clk);
    chk("done_cycle_overrun", 32'(ovr0), 32'd1);
    chk("done_cycle_ignored", 32'(busy0), 32'd0);
    @(negedge clk);
    start0 = 1'b0;
    acc_cyc = cyc_now;
    chk("after_done_accept", 32'(busy0), 32'd1);
    finish_seq(0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;

    // reset during the second half of bit 10 of ch0
    scramble(0);
    start_seq(0);
    repeat (21) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_sync_n", 32'(if0.dac_sync_n), 32'd1);
    chk("mid_rst_sclk", 32'(if0.dac_sclk), 32'd1);
    chk("mid_rst_din", 32'(if0.dac_din), 32'd0);
    chk("mid_rst_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    #1 mq.delete();
    rst_n = 1'b1;
    scramble(0);
    start_seq(0); finish_seq(0);

    // 4 channels, 8-bit samples, CLK_DIV 4
    src_a1 = {4{8'h5A}}; src_b1 = $urandom; mode1 = {4{2'd1}};
    start_seq(1); finish_seq(1);
    for (int r = 0; r < 2; r++) begin
      scramble(1);
      start_seq(1);
      repeat (100) @(negedge clk);
      scramble(1);
      finish_seq(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
